fsram_pair_reader: RTL and testbench

- Read-side counterpart of the FSRAM fill path. The fill path packs two vertically adjacent 8-bit pixels into one 16-bit FSRAM word: {pixel(2p,c), pixel(2p+1,c)}.
- This block walks one stored feature map through FSRAM port B, unpacks each word, and emits a byte stream with a valid/ready handshake to the downstream data-process / CCM consumer.
- It sits between the FSRAM macro port B and the consumer. It owns CENB/AB during a transfer.

---
 rtl/fsram_pair_reader.sv | 131 +++++++++++++
 tb/tb_fsram_pair_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fsram_pair_reader.sv
// Streams one stored feature map out of FSRAM port B, splitting each packed word into two bytes.
// Build option FSRAM_SNAKE_ORDER_EN: odd pair-rows are walked right-to-left to match zig-zag fill order.
module fsram_pair_reader #(
    parameter int ROW        = 16,
    parameter int COL        = 256,
    parameter int ADDR_W     = 12,
    parameter int FIFO_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              CENB,
    output logic [ADDR_W-1:0] AB,
    input  logic [15:0]       QB,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done
);
    localparam int WORDS = ROW / 2 * COL;
    localparam int WW    = $clog2(WORDS + 1);
    localparam int CW    = (COL > 1) ? $clog2(COL) : 1;
    localparam int PW    = (ROW > 2) ? $clog2(ROW / 2) : 1;
    localparam int PTR_W = $clog2(FIFO_BYTES);
    localparam int CNT_W = $clog2(FIFO_BYTES + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] base_reg, ab_reg, issue_addr;
    logic [PW-1:0]     p_reg;
    logic [CW-1:0]     c_reg, c_eff;
    logic [WW-1:0]     issued_reg;
    logic              inflight_reg, done_reg;
    logic [7:0]        fifo_mem [FIFO_BYTES];
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [31:0]       offset;
    logic              issue, pop, last_pop, accept;

    // Column actually addressed for the current pair-row.
    always_comb begin
`ifdef FSRAM_SNAKE_ORDER_EN
        c_eff = p_reg[0] ? (CW'(COL - 1) - c_reg) : c_reg;
`else
        c_eff = c_reg;
`endif
        offset     = 32'(p_reg) * 32'(COL) + 32'(c_eff);
        issue_addr = base_reg + offset[ADDR_W-1:0];
    end

    // Reserve room for the in-flight word plus the one about to be issued.
    assign issue = (state_reg == READ) && (issued_reg < WW'(WORDS)) &&
                   ((int'(count_reg) + 2 * int'(inflight_reg) + 2) <= FIFO_BYTES);
    assign pop      = (count_reg != '0) && byte_ready;
    assign last_pop = (state_reg == DRAIN) && !inflight_reg && (count_reg == CNT_W'(1)) && pop;
    // A start landing on the done cycle is dropped.
    assign accept   = (state_reg == IDLE) && start && !done_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = READ;
            READ:    if (issue && (issued_reg == WW'(WORDS - 1))) state_next = DRAIN;
            DRAIN:   if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            ab_reg       <= '0;
            p_reg        <= '0;
            c_reg        <= '0;
            issued_reg   <= '0;
            inflight_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            done_reg     <= last_pop;
            inflight_reg <= issue;
            if (accept) begin
                base_reg   <= base_addr;
                p_reg      <= '0;
                c_reg      <= '0;
                issued_reg <= '0;
            end
            if (issue) begin
                ab_reg     <= issue_addr;
                issued_reg <= issued_reg + WW'(1);
                if (c_reg == CW'(COL - 1)) begin
                    c_reg <= '0;
                    p_reg <= p_reg + PW'(1);
                end else begin
                    c_reg <= c_reg + CW'(1);
                end
            end
        end
    end

    // Byte buffer: captured word lands as high byte then low byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_BYTES; i++) fifo_mem[i] <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (inflight_reg) begin
                fifo_mem[wr_ptr_reg]              <= QB[15:8];
                fifo_mem[wr_ptr_reg + PTR_W'(1)]  <= QB[7:0];
                wr_ptr_reg                        <= wr_ptr_reg + PTR_W'(2);
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + (inflight_reg ? CNT_W'(2) : CNT_W'(0))
                                   - (pop ? CNT_W'(1) : CNT_W'(0));
        end
    end

    assign CENB       = !issue;
    assign AB         = issue ? issue_addr : ab_reg;
    assign byte_out   = fifo_mem[rd_ptr_reg];
    assign byte_valid = (count_reg != '0);
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;

endmodule

// File: tb/tb_fsram_pair_reader.sv
// Directed bench for fsram_pair_reader with a 4x4 map and word(a) = {a[7:0], ~a[7:0]}.
module tb_fsram_pair_reader;
    localparam int ROW    = 4;
    localparam int COL    = 4;
    localparam int ADDR_W = 12;
    localparam int WORDS  = ROW / 2 * COL;
    localparam int BYTES  = ROW * COL;

    logic              clk, rst_n, start, CENB, byte_valid, byte_ready, busy, done;
    logic [ADDR_W-1:0] base_addr, AB;
    logic [15:0]       QB;
    logic [7:0]        byte_out;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    logic [ADDR_W-1:0] ab_q[$];
    logic [7:0]        byte_q[$];

    fsram_pair_reader #(.ROW(ROW), .COL(COL), .ADDR_W(ADDR_W), .FIFO_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .CENB(CENB), .AB(AB), .QB(QB),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous FSRAM port B model.
    always @(posedge clk) begin
        if (!CENB) QB <= {AB[7:0], ~AB[7:0]};
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!CENB) ab_q.push_back(AB);
            if (byte_valid && byte_ready) byte_q.push_back(byte_out);
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] b, input int i);
        int p, c;
        logic [31:0] a;
        p = i / COL;
        c = i % COL;
`ifdef FSRAM_SNAKE_ORDER_EN
        if (p % 2 == 1) c = COL - 1 - c;
`endif
        a = 32'(b) + 32'(p * COL + c);
        return a[ADDR_W-1:0];
    endfunction

    task automatic start_xfer(input logic [ADDR_W-1:0] b);
        ab_q.delete();
        byte_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic verify_stream(input string tag, input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] a;
        logic [7:0]        e;
        check({tag, "_nwords"}, 32'(ab_q.size()), 32'(WORDS));
        for (int i = 0; i < WORDS; i++)
            if (i < ab_q.size()) check($sformatf("%s_ab%0d", tag, i), 32'(ab_q[i]), 32'(exp_addr(b, i)));
        check({tag, "_nbytes"}, 32'(byte_q.size()), 32'(BYTES));
        for (int i = 0; i < BYTES; i++) begin
            a = exp_addr(b, i / 2);
            e = (i % 2 == 1) ? ~a[7:0] : a[7:0];
            if (i < byte_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(byte_q[i]), 32'(e));
        end
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        $display("[TB] xfer %s base=0x%03h words=%0d bytes=%0d done=%0d",
                 tag, b, ab_q.size(), byte_q.size(), done_cnt);
    endtask

    initial begin
        int n0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cenb", 32'(CENB), 32'd1);
        check("rst_ab", 32'(AB), 32'd0);
        check("rst_byte_out", 32'(byte_out), 32'd0);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Plain transfer at full rate
        start_xfer(12'h010);
        wait_done("basic");
        verify_stream("basic", 12'h010);

        // Consumer stall right after the first byte appears
        byte_ready = 1'b0;
        start_xfer(12'h010);
        for (int k = 0; k < 20 && !byte_valid; k++) begin
            @(posedge clk); #1;
        end
        check("bp_valid", 32'(byte_valid), 32'd1);
        n0 = ab_q.size();
        repeat (10) begin
            check("bp_hold", 32'(byte_out), 32'h10);
            @(posedge clk); #1;
        end
        check("bp_issue_le2", 32'((ab_q.size() - n0) <= 2), 32'd1);
        byte_ready = 1'b1;
        wait_done("bp");
        verify_stream("bp", 12'h010);

        // Address wraps past the top of FSRAM
        start_xfer(12'hFFE);
        wait_done("wrap");
        verify_stream("wrap", 12'hFFE);
        if (byte_q.size() >= 2) begin
            check("wrap_first_hi", 32'(byte_q[0]), 32'hFE);
            check("wrap_first_lo", 32'(byte_q[1]), 32'h01);
        end

        // Reset in the middle of a transfer, then replay
        start_xfer(12'h010);
        for (int k = 0; k < 100 && byte_q.size() < 5; k++) begin
            @(posedge clk); #1;
        end
        check("midrst_reached5", 32'(byte_q.size() >= 5), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_cenb", 32'(CENB), 32'd1);
        check("midrst_valid", 32'(byte_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        start_xfer(12'h010);
        wait_done("replay");
        verify_stream("replay", 12'h010);

        // Second start during READ, then a start on the done cycle
        start_xfer(12'h010);
        @(posedge clk); #1;
        check("busy_during_read", 32'(busy), 32'd1);
        base_addr = 12'h100;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check("collide_done", 32'(done), 32'd1);
        base_addr = 12'h020;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        check("collide_busy", 32'(busy), 32'd0);
        check("collide_cenb", 32'(CENB), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("collide_still_idle", 32'(busy), 32'd0);
        verify_stream("busy_start", 12'h010);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
